// File: rtl/slave_mem_pkg.sv
// slave_mem_pkg: shared types and constants for the slave_mem_array block.
//   resp_t      - one response pipeline entry {valid, err, rdata}; rdata is
//                 sized for the widest supported DATA_W, narrower builds keep
//                 the upper bits at zero.
//   lane_count  - number of byte lanes in a data word.
//   RD_LAT_MIN/RD_LAT_MAX - supported response latency range.
package slave_mem_pkg;

   localparam int unsigned RD_LAT_MIN  = 1;
   localparam int unsigned RD_LAT_MAX  = 4;
   localparam int unsigned RDATA_MAX_W = 128;

   typedef struct packed {
      logic                   valid;
      logic                   err;
      logic [RDATA_MAX_W-1:0] rdata;
   } resp_t;

   function automatic int unsigned lane_count(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/slave_mem_resp_pipe.sv
// slave_mem_resp_pipe: RD_LAT-stage shift pipeline carrying response entries.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset; flushes every stage
//   entry  - response captured at the request accept edge
//   result - oldest stage; all-zero whenever its valid bit is clear
// RD_LAT is clamped to the package latency bounds.
module slave_mem_resp_pipe
   import slave_mem_pkg::*;
#(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned DATA_W = 32
) (
   input  logic  clk,
   input  logic  rst,
   input  resp_t entry,
   output resp_t result
);

   localparam int unsigned STAGES = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                    (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
   localparam logic [RDATA_MAX_W-1:0] DATA_MASK = {RDATA_MAX_W{1'b1}} >> (RDATA_MAX_W - DATA_W);

   resp_t masked;
   resp_t stage [STAGES];

   always_comb begin
      masked       = entry;
      masked.rdata = entry.rdata & DATA_MASK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= masked;
         for (int unsigned i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   always_comb begin
      result = '0;
      if (stage[STAGES-1].valid) begin
         result = stage[STAGES-1];
      end
   end

endmodule

// File: rtl/slave_mem_array.sv
// slave_mem_array: byte-strobed word memory slave with a fixed-latency,
// in-order response pipeline. One request may be accepted every cycle.
// Ports:
//   sys_clk   - rising-edge clock
//   sys_rst   - asynchronous active-high reset (pipeline only, not storage)
//   sys_addr  - byte address; word index = sys_addr >> log2(DATA_W/8)
//   sys_wdata - write data
//   sys_sel   - byte-lane write strobes
//   sys_wen   - write request
//   sys_ren   - read request
//   sys_rdata - read data, nonzero only with sys_ack of a good read
//   sys_ack   - one-cycle response pulse, RD_LAT cycles after acceptance
//   sys_err   - error flag, qualified by sys_ack
// Build option: define SLAVE_MEM_ERR_CHK_EN to flag out-of-range, misaligned
// and empty-strobe requests; otherwise the index wraps, alignment bits are
// ignored and only a read/write collision is an error.
module slave_mem_array
   import slave_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned RD_LAT      = 1
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [ADDR_W-1:0]          sys_addr,
   input  logic [DATA_W-1:0]          sys_wdata,
   input  logic [lane_count(DATA_W)-1:0] sys_sel,
   input  logic                       sys_wen,
   input  logic                       sys_ren,
   output logic [DATA_W-1:0]          sys_rdata,
   output logic                       sys_ack,
   output logic                       sys_err
);

   localparam int unsigned LANES     = lane_count(DATA_W);
   localparam int unsigned LANE_BITS = $clog2(LANES);
   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] LANE_MASK   = ADDR_W'((1 << LANE_BITS) - 1);
   localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH_WORDS);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   logic [ADDR_W-1:0] word_addr;
   logic [IDX_W-1:0]  idx;
   logic              collide;
   logic              req;
   logic              req_err;
   logic              do_write;
   logic              do_read;
   resp_t             entry;
   resp_t             result;
   logic              unused_bits;

   assign word_addr = sys_addr >> LANE_BITS;
   assign idx       = word_addr[IDX_W-1:0];
   assign collide   = sys_wen & sys_ren;
   assign req       = sys_wen | sys_ren;

`ifdef SLAVE_MEM_ERR_CHK_EN
   assign req_err = collide
                  | (word_addr >= DEPTH_LIMIT)
                  | ((sys_addr & LANE_MASK) != '0)
                  | (sys_wen & (sys_sel == '0));
`else
   assign req_err = collide;
`endif

   // Requests presented while reset is held are never accepted.
   assign do_write = sys_wen & ~sys_ren & ~req_err & ~sys_rst;
   assign do_read  = sys_ren & ~sys_wen & ~req_err;

   // Storage is deliberately left out of reset.
   always_ff @(posedge sys_clk) begin
      if (do_write) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (sys_sel[i]) begin
               mem[idx][i*8 +: 8] <= sys_wdata[i*8 +: 8];
            end
         end
      end
   end

   // Array is sampled combinationally so the entry captured at the accept
   // edge already sees a write accepted one edge earlier.
   always_comb begin
      entry       = '0;
      entry.valid = req;
      entry.err   = req & req_err;
      if (do_read) begin
         entry.rdata[DATA_W-1:0] = mem[idx];
      end
   end

   slave_mem_resp_pipe #(
      .RD_LAT (RD_LAT),
      .DATA_W (DATA_W)
   ) u_resp_pipe (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .entry  (entry),
      .result (result)
   );

   assign sys_ack   = result.valid;
   assign sys_err   = result.err;
   assign sys_rdata = result.rdata[DATA_W-1:0];

   // Address bits outside the index and padding above DATA_W are not needed
   // in every configuration.
   assign unused_bits = ^{sys_addr, result.rdata};

endmodule

// File: tb/tb_slave_mem_array.sv
module tb_slave_mem_array;

   localparam int LAT = 3;
`ifdef SLAVE_MEM_ERR_CHK_EN
   localparam bit E = 1'b1;
`else
   localparam bit E = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  sel;
   logic        wen;
   logic        ren;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   slave_mem_array #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .DEPTH_WORDS (64),
      .RD_LAT      (LAT)
   ) dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .sys_addr  (addr),
      .sys_wdata (wdata),
      .sys_sel   (sel),
      .sys_wen   (wen),
      .sys_ren   (ren),
      .sys_rdata (rdata),
      .sys_ack   (ack),
      .sys_err   (err)
   );

   typedef struct {
      string       name;
      logic        wen;
      logic        ren;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; sel = '0;
   endtask

   task automatic drive(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      wen = w; ren = r; addr = a; wdata = d; sel = s;
   endtask

   task automatic check_quiet(input string name);
      check({name, "_ack"},   32'(ack), 32'd0);
      check({name, "_err"},   32'(err), 32'd0);
      check({name, "_rdata"}, rdata,    32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // name, wen, ren, addr, wdata, sel, exp_err, exp_rdata
      vecs.push_back('{"wr_dead",  1, 0, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0});
      vecs.push_back('{"rd_dead",  0, 1, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF});
      vecs.push_back('{"wr_aa",    1, 0, 32'h20,  32'hAAAAAAAA, 4'hF, 0, 32'h0});
      vecs.push_back('{"wr_sel5",  1, 0, 32'h20,  32'h11223344, 4'h5, 0, 32'h0});
      vecs.push_back('{"rd_sel5",  0, 1, 32'h20,  32'h0,        4'h0, 0, 32'hAA22AA44});
      vecs.push_back('{"wr_ff",    1, 0, 32'h30,  32'hFFFFFFFF, 4'hF, 0, 32'h0});
      vecs.push_back('{"wr_selA",  1, 0, 32'h30,  32'h00000000, 4'hA, 0, 32'h0});
      vecs.push_back('{"rd_selA",  0, 1, 32'h30,  32'h0,        4'h0, 0, 32'h00FF00FF});
      vecs.push_back('{"wr_cafe",  1, 0, 32'h40,  32'hCAFEF00D, 4'hF, 0, 32'h0});
      vecs.push_back('{"collide",  1, 1, 32'h40,  32'h00000000, 4'hF, 1, 32'h0});
      vecs.push_back('{"rd_cafe",  0, 1, 32'h40,  32'h0,        4'h0, 0, 32'hCAFEF00D});
      vecs.push_back('{"wr_w0",    1, 0, 32'h0,   32'h12345678, 4'hF, 0, 32'h0});
      vecs.push_back('{"wr_oob",   1, 0, 32'h100, 32'h0BADF00D, 4'hF, E, 32'h0});
      vecs.push_back('{"rd_w0",    0, 1, 32'h0,   32'h0,        4'h0, 0, E ? 32'h12345678 : 32'h0BADF00D});
      vecs.push_back('{"rd_mis",   0, 1, 32'h2,   32'h0,        4'h0, E, E ? 32'h0 : 32'h0BADF00D});
      vecs.push_back('{"wr_w2",    1, 0, 32'h8,   32'h01020304, 4'hF, 0, 32'h0});
      vecs.push_back('{"wr_sel0",  1, 0, 32'h8,   32'h55555555, 4'h0, E, 32'h0});
      vecs.push_back('{"rd_w2",    0, 1, 32'h8,   32'h0,        4'h0, 0, 32'h01020304});

      // Reset state
      rst = 1'b1;
      idle();
      #1;
      check_quiet("rst0");
      repeat (2) begin
         @(negedge clk);
         check_quiet("rst_hold");
      end
      rst = 1'b0;

      // One request at a time: ack exactly LAT cycles after acceptance.
      for (int v = 0; v < vecs.size(); v++) begin
         @(negedge clk);
         drive(vecs[v].wen, vecs[v].ren, vecs[v].addr, vecs[v].wdata, vecs[v].sel);
         for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) idle();
            check({vecs[v].name, "_ack"}, 32'(ack), 32'(k == LAT));
            if (k == LAT) begin
               check({vecs[v].name, "_err"},   32'(err), 32'(vecs[v].exp_err));
               check({vecs[v].name, "_rdata"}, rdata,    vecs[v].exp_rdata);
            end
         end
      end

      // Back-to-back: three writes then three reads, six consecutive acks.
      begin
         logic [31:0] b2b_data [3];
         b2b_data[0] = 32'h11111111;
         b2b_data[1] = 32'h22222222;
         b2b_data[2] = 32'h33333333;
         @(negedge clk);
         for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
               check("b2b_ack", 32'(ack), 32'(k >= LAT && k <= LAT + 5));
               if (k >= LAT && k <= LAT + 5) check("b2b_err", 32'(err), 32'd0);
               if (k >= LAT + 3 && k <= LAT + 5)
                  check("b2b_rdata", rdata, b2b_data[k-LAT-3]);
               else
                  check("b2b_rdata_zero", rdata, 32'd0);
            end
            if (k < 3)
               drive(1'b1, 1'b0, 32'(4 * k), b2b_data[k], 4'hF);
            else if (k < 6)
               drive(1'b0, 1'b1, 32'(4 * (k - 3)), 32'h0, 4'h0);
            else
               idle();
            @(negedge clk);
         end
      end

      // Reset with two reads in flight: they must never be acknowledged.
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
      @(negedge clk);
      idle();
      rst = 1'b1;
      #1;
      check_quiet("mid_rst");
      repeat (3) begin
         @(negedge clk);
         check_quiet("mid_rst_hold");
      end
      // First edge after release accepts a request; storage survived reset.
      rst = 1'b0;
      drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         if (k == 1) idle();
         check("post_rst_ack", 32'(ack), 32'(k == LAT));
         if (k == LAT) begin
            check("post_rst_err",   32'(err), 32'd0);
            check("post_rst_rdata", rdata,    32'hDEADBEEF);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/slave_mem_array.md
SLAVE_MEM_ARRAY -- requirements
Module: slave_mem_array

Interface
Parameters:
REQ-001 The module SHALL have parameter DATA_W, default 32: data width in bits; a multiple of 8, range 8..128.
REQ-002 The module SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 The module SHALL have parameter DEPTH_WORDS, default 1024: storage depth in DATA_W-bit words; a power of two.
REQ-004 The module SHALL have parameter RD_LAT, default 1: response latency in cycles, range 1..4.

Ports:
REQ-005 The module SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The module SHALL have port sys_addr, input, ADDR_W bits: byte address of the request.
REQ-008 The module SHALL have port sys_wdata, input, DATA_W bits: write data.
REQ-009 The module SHALL have port sys_sel, input, DATA_W/8 bits: byte-lane write strobes.
REQ-010 The module SHALL have port sys_wen, input, 1 bit: write request.
REQ-011 The module SHALL have port sys_ren, input, 1 bit: read request.
REQ-012 The module SHALL have port sys_rdata, output, DATA_W bits: read data.
REQ-013 The module SHALL have port sys_ack, output, 1 bit: response-valid pulse.
REQ-014 The module SHALL have port sys_err, output, 1 bit: error flag, qualified by sys_ack.

Function
REQ-015 A request SHALL be accepted on every rising edge where sys_wen or sys_ren is high; there is no back-pressure, so one request can be accepted per cycle.
REQ-016 Word index SHALL be sys_addr >> log2(DATA_W/8); low address bits select the alignment check only.
REQ-017 An accepted error-free write SHALL update, at the accept edge, only the byte lanes whose sys_sel bit is 1; other lanes are unchanged.
REQ-018 An accepted read SHALL sample the array at the accept edge; a write accepted on the previous edge to the same word SHALL be visible.
REQ-019 Every accepted request SHALL produce exactly one sys_ack pulse, one cycle wide, RD_LAT cycles after acceptance; responses SHALL be in order and back-to-back capable.
REQ-020 sys_rdata SHALL be valid only while sys_ack is 1 for a read; for writes and errored reads it SHALL be all-zero.
REQ-021 sys_wen and sys_ren both high in the same cycle SHALL be an error: no array update, sys_err=1 with the ack.
REQ-022 The response path SHALL be an RD_LAT-stage shift pipeline carrying {valid, err, rdata}; no FSM beyond this pipeline is required.

Reset
REQ-023 While sys_rst=1: sys_ack=0, sys_err=0, sys_rdata=0, and all pipeline valid bits are cleared.
REQ-024 Requests in flight when reset asserts SHALL be discarded and never acknowledged.
REQ-025 Array contents SHALL NOT be reset.
REQ-026 The first request SHALL be accepted on the first rising edge after sys_rst deasserts.

Configuration
REQ-027 The module SHALL compile its error checks in or out with the macro SLAVE_MEM_ERR_CHK_EN.
REQ-028 With SLAVE_MEM_ERR_CHK_EN defined, sys_err SHALL be 1 with the ack for any of:
- word index >= DEPTH_WORDS;
- nonzero low alignment bits;
- a write with sys_sel=0;
- the collision case in REQ-021.
REQ-029 With SLAVE_MEM_ERR_CHK_EN defined, errored writes SHALL NOT modify the array.
REQ-030 With SLAVE_MEM_ERR_CHK_EN undefined:
- the word index SHALL wrap modulo DEPTH_WORDS;
- alignment bits SHALL be ignored;
- sys_err SHALL be 1 only for the collision case.

Structure
REQ-031 Package slave_mem_pkg SHALL hold:
- the response struct typedef {valid, err, rdata};
- the lane-count function DATA_W/8;
- the RD_LAT bounds constants.
REQ-032 The response pipeline SHALL be a sub-module named slave_mem_resp_pipe, parametrised by RD_LAT and DATA_W.

Verification
REQ-033 Write 0xDEADBEEF to 0x10 with sel=0xF, then read 0x10 -> ack after RD_LAT cycles, rdata=0xDEADBEEF, err=0.
REQ-034 Write 0x11223344 to 0x20 with sel=0x5 over prior 0xAAAAAAAA, then read -> rdata=0xAA22AA44.
REQ-035 Back-to-back writes to 0x0, 0x4, 0x8 followed by three reads with RD_LAT=3 -> six consecutive ack pulses, reads returning data in order.
REQ-036 With SLAVE_MEM_ERR_CHK_EN defined:
- read 0x2 -> err=1;
- write to byte address 4*DEPTH_WORDS -> err=1 and word 0 unchanged.
With the macro undefined, the same write lands in word 0.
REQ-037 wen=ren=1 at 0x40 -> single ack with err=1 and memory unchanged.
REQ-038 Assert sys_rst mid-stream with 2 requests in flight -> no acks for them, outputs 0 during reset.
